// File: rtl/action_responder.sv
// Turns click-detector action codes into cursor moves and reveal/flag requests,
// with a single ACK pulse per action and a release wait against re-triggering.
module action_responder #(
   parameter int unsigned ROWS = 16,
   parameter int unsigned COLS = 16
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic [2:0] Action,
   output logic       ACK,
   input  logic       game_over,
   output logic [3:0] cur_row,
   output logic [3:0] cur_col,
   output logic       op_valid,
   output logic       op_code,
   output logic [3:0] op_row,
   output logic [3:0] op_col,
   input  logic       op_ready
);

   localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
   localparam logic [3:0] COL_MAX = 4'(COLS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      ACKN    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       w_ack_nxt;
   logic [3:0] w_row_nxt;
   logic [3:0] w_col_nxt;
   logic       w_valid_nxt;
   logic       w_code_nxt;
   logic [3:0] w_op_row_nxt;
   logic [3:0] w_op_col_nxt;

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_ack_nxt    = 1'b0;
      w_row_nxt    = cur_row;
      w_col_nxt    = cur_col;
      w_valid_nxt  = op_valid;
      w_code_nxt   = op_code;
      w_op_row_nxt = op_row;
      w_op_col_nxt = op_col;

      case (r_state)
         IDLE: begin
            case (Action)
               3'b000: w_state_nxt = IDLE;
               3'b100: begin
                  if (cur_row != 4'd0) w_row_nxt = cur_row - 4'd1;
                  w_state_nxt = ACKN;
               end
               3'b110: begin
                  if (cur_row < ROW_MAX) w_row_nxt = cur_row + 4'd1;
                  w_state_nxt = ACKN;
               end
               3'b111: begin
                  if (cur_col != 4'd0) w_col_nxt = cur_col - 4'd1;
                  w_state_nxt = ACKN;
               end
               3'b101: begin
                  if (cur_col < COL_MAX) w_col_nxt = cur_col + 4'd1;
                  w_state_nxt = ACKN;
               end
               3'b001, 3'b010: begin
                  if (!game_over) begin
                     w_valid_nxt  = 1'b1;
                     w_code_nxt   = Action[1];
                     w_op_row_nxt = cur_row;
                     w_op_col_nxt = cur_col;
                     w_state_nxt  = ISSUE;
                  end else begin
                     w_state_nxt  = ACKN;
                  end
               end
               default: w_state_nxt = ACKN;
            endcase
         end
         // Request held stable until the board takes it; game_over cannot withdraw it
         ISSUE: begin
            if (op_ready) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ACKN;
            end
         end
         ACKN: begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = RELEASE;
         end
         RELEASE: begin
            if (Action == 3'b000) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state  <= IDLE;
         ACK      <= 1'b0;
         cur_row  <= 4'd0;
         cur_col  <= 4'd0;
         op_valid <= 1'b0;
         op_code  <= 1'b0;
         op_row   <= 4'd0;
         op_col   <= 4'd0;
      end else begin
         r_state  <= w_state_nxt;
         ACK      <= w_ack_nxt;
         cur_row  <= w_row_nxt;
         cur_col  <= w_col_nxt;
         op_valid <= w_valid_nxt;
         op_code  <= w_code_nxt;
         op_row   <= w_op_row_nxt;
         op_col   <= w_op_col_nxt;
      end
   end

endmodule

// File: tb/tb_action_responder.sv
// Bench for action_responder: directed scenarios with literal expectations,
// then random actions checked every cycle against a transaction-level model.
module tb_action_responder;

   localparam int ROWS = 8;
   localparam int COLS = 6;

   logic       clk;
   logic       clear_n;
   logic [2:0] Action;
   logic       ACK;
   logic       game_over;
   logic [3:0] cur_row;
   logic [3:0] cur_col;
   logic       op_valid;
   logic       op_code;
   logic [3:0] op_row;
   logic [3:0] op_col;
   logic       op_ready;

   int n_chk  = 0;
   int n_fail = 0;

   action_responder #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .Action    (Action),
      .ACK       (ACK),
      .game_over (game_over),
      .cur_row   (cur_row),
      .cur_col   (cur_col),
      .op_valid  (op_valid),
      .op_code   (op_code),
      .op_row    (op_row),
      .op_col    (op_col),
      .op_ready  (op_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: an action is a transaction -- optional request phase that
   // lasts until op_ready, one ACK cycle later, then a wait for Action to go idle.
   int m_row = 0, m_col = 0;
   int m_valid = 0, m_code = 0, m_orow = 0, m_ocol = 0;
   int m_ack = 0, m_ack_due = 0, m_wait_zero = 0;

   always @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         m_row <= 0; m_col <= 0; m_valid <= 0; m_code <= 0;
         m_orow <= 0; m_ocol <= 0; m_ack <= 0; m_ack_due <= 0; m_wait_zero <= 0;
      end else if (m_ack_due != 0) begin
         m_ack       <= 1;
         m_ack_due   <= 0;
         m_wait_zero <= 1;
      end else begin
         m_ack <= 0;
         if (m_valid != 0) begin
            if (op_ready) begin
               m_valid   <= 0;
               m_ack_due <= 1;
            end
         end else if (m_wait_zero != 0) begin
            if (Action == 3'b000) m_wait_zero <= 0;
         end else if (Action != 3'b000) begin
            if (Action == 3'b100)      m_row <= (m_row > 0) ? m_row - 1 : 0;
            else if (Action == 3'b110) m_row <= (m_row < ROWS - 1) ? m_row + 1 : ROWS - 1;
            else if (Action == 3'b111) m_col <= (m_col > 0) ? m_col - 1 : 0;
            else if (Action == 3'b101) m_col <= (m_col < COLS - 1) ? m_col + 1 : COLS - 1;
            if ((Action == 3'b001 || Action == 3'b010) && !game_over) begin
               m_valid <= 1;
               m_code  <= (Action == 3'b010) ? 1 : 0;
               m_orow  <= m_row;
               m_ocol  <= m_col;
            end else begin
               m_ack_due <= 1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("ack",      32'(ACK),      32'(m_ack));
      chk("cur_row",  32'(cur_row),  32'(m_row));
      chk("cur_col",  32'(cur_col),  32'(m_col));
      chk("op_valid", 32'(op_valid), 32'(m_valid));
      if (m_valid != 0) begin
         chk("op_code", 32'(op_code), 32'(m_code));
         chk("op_row",  32'(op_row),  32'(m_orow));
         chk("op_col",  32'(op_col),  32'(m_ocol));
      end
   end

   task automatic step(input logic [2:0] a, input logic rdy, input logic go);
      @(negedge clk);
      Action    = a;
      op_ready  = rdy;
      game_over = go;
      @(posedge clk);
      #1;
   endtask

   task automatic move(input logic [2:0] a);
      step(a, 1'b0, 1'b0);
      step(3'b000, 1'b0, 1'b0);
      step(3'b000, 1'b0, 1'b0);
   endtask

   logic [2:0] r_act;

   initial begin
      clear_n = 1'b0; Action = 3'b000; op_ready = 1'b0; game_over = 1'b0;
      #2;
      chk("rst_ack",   32'(ACK),      32'd0);
      chk("rst_valid", 32'(op_valid), 32'd0);
      chk("rst_row",   32'(cur_row),  32'd0);
      chk("rst_col",   32'(cur_col),  32'd0);
      chk("rst_oprow", 32'(op_row),   32'd0);
      repeat (2) @(negedge clk);
      clear_n = 1'b1;

      // Single D move, ACK one cycle later, then back to IDLE
      step(3'b110, 1'b0, 1'b0);
      chk("d_row", 32'(cur_row), 32'd1);
      chk("d_ack0", 32'(ACK), 32'd0);
      step(3'b000, 1'b0, 1'b0);
      chk("d_ack1", 32'(ACK), 32'd1);
      step(3'b000, 1'b0, 1'b0);
      chk("d_ack2", 32'(ACK), 32'd0);
      step(3'b101, 1'b0, 1'b0);
      chk("idle_r", 32'(cur_col), 32'd1);
      step(3'b000, 1'b0, 1'b0);
      step(3'b000, 1'b0, 1'b0);

      // Saturation at the origin
      move(3'b100);
      move(3'b111);
      step(3'b100, 1'b0, 1'b0);
      chk("sat_u_row", 32'(cur_row), 32'd0);
      step(3'b000, 1'b0, 1'b0);
      chk("sat_u_ack", 32'(ACK), 32'd1);
      step(3'b000, 1'b0, 1'b0);
      step(3'b111, 1'b0, 1'b0);
      chk("sat_l_col", 32'(cur_col), 32'd0);
      step(3'b000, 1'b0, 1'b0);
      chk("sat_l_ack", 32'(ACK), 32'd1);
      step(3'b000, 1'b0, 1'b0);

      // Flag request at (3,5) with op_ready held low for 4 cycles
      repeat (3) move(3'b110);
      repeat (6) move(3'b101);
      chk("col_max", 32'(cur_col), 32'd5);
      step(3'b010, 1'b0, 1'b0);
      chk("flag_valid", 32'(op_valid), 32'd1);
      chk("flag_code",  32'(op_code),  32'd1);
      chk("flag_row",   32'(op_row),   32'd3);
      chk("flag_col",   32'(op_col),   32'd5);
      for (int i = 0; i < 4; i++) begin
         step((i == 2) ? 3'b100 : 3'b010, 1'b0, 1'b1);
         chk("wait_valid", 32'(op_valid), 32'd1);
         chk("wait_row",   32'(op_row),   32'd3);
         chk("wait_col",   32'(op_col),   32'd5);
         chk("wait_cur",   32'(cur_row),  32'd3);
         chk("wait_ack",   32'(ACK),      32'd0);
      end
      step(3'b010, 1'b1, 1'b0);
      chk("accept_valid", 32'(op_valid), 32'd0);
      chk("accept_ack",   32'(ACK),      32'd0);
      step(3'b010, 1'b0, 1'b0);
      chk("flag_ack", 32'(ACK), 32'd1);

      // Stale held code must not be processed again
      for (int i = 0; i < 6; i++) begin
         step(3'b001, 1'b1, 1'b0);
         chk("stale_valid", 32'(op_valid), 32'd0);
         chk("stale_ack",   32'(ACK),      32'd0);
      end
      step(3'b000, 1'b0, 1'b0);
      chk("release_ack", 32'(ACK), 32'd0);

      // Cell operation suppressed by game_over
      step(3'b001, 1'b0, 1'b1);
      chk("go_valid", 32'(op_valid), 32'd0);
      step(3'b000, 1'b0, 1'b1);
      chk("go_ack",   32'(ACK),      32'd1);
      step(3'b000, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a request
      step(3'b001, 1'b0, 1'b0);
      chk("pre_rst_valid", 32'(op_valid), 32'd1);
      @(negedge clk);
      #2 clear_n = 1'b0;
      #1;
      chk("arst_valid", 32'(op_valid), 32'd0);
      chk("arst_row",   32'(cur_row),  32'd0);
      chk("arst_col",   32'(cur_col),  32'd0);
      @(negedge clk);
      Action = 3'b000;
      clear_n = 1'b1;
      step(3'b101, 1'b0, 1'b0);
      chk("post_rst_col", 32'(cur_col), 32'd1);
      step(3'b000, 1'b0, 1'b0);
      chk("post_rst_ack", 32'(ACK), 32'd1);
      step(3'b000, 1'b0, 1'b0);

      // Randomized traffic with occasional off-edge resets
      r_act = 3'b000;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 99) < 35)
            r_act = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
         if ($urandom_range(0, 399) == 0) begin
            @(negedge clk);
            #3 clear_n = 1'b0;
            #1;
            chk("rnd_arst_valid", 32'(op_valid), 32'd0);
            chk("rnd_arst_ack",   32'(ACK),      32'd0);
            @(negedge clk);
            clear_n = 1'b1;
         end
         step(r_act, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0));
      end
      step(3'b000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
